outarb: RTL and testbench
=========================

OUTARB -- requirements
Module: outarb

Interface
REQ-001 SHALL: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL: req  input  `PORT+1 (4)  bit i set = input port i requests this output port.
REQ-004 SHALL: pkt0..pkt3  input  `PKTW+1 each  head-of-FIFO flit from input port i; flow field at [`FLOWBH:`FLOWBL].
REQ-005 SHALL: ack  output  4  one-hot grant pulse to the winning input port.
REQ-006 SHALL: sel  output  2  index of the currently granted input port.
REQ-007 SHALL: pkto  output  `PKTW+1  flit forwarded to the output link.
REQ-008 SHALL: we  output  1  write strobe; pkto is valid while we=1.
REQ-009 SHALL: busy  output  1  high from grant until the TAIL flit has been forwarded.
REQ-010 SHALL: npkt  output  16  count of completed packets; saturates at 16'hFFFF.

Function
REQ-011 SHALL: use three states: IDLE, GRANT, BUSY.
REQ-012 SHALL: IDLE with req==0 -> stay IDLE; all outputs 0 except sel/npkt, which hold.
REQ-013 SHALL: IDLE with req!=0 -> register winner into sel, go to GRANT next cycle.
REQ-014 SHALL: winner = first set req bit, searching upward (mod 4) from the last winner + 1 (round-robin).
REQ-015 SHALL: GRANT -> ack[sel]=1 for exactly this one cycle, we=1, pkto=pkt[sel] (HEAD flit), busy=1; go to BUSY.
REQ-016 SHALL: BUSY -> ack=0, we=1, pkto=pkt[sel] combinationally every cycle, busy=1.
REQ-017 SHALL: BUSY -> flow field of pkt[sel]==`TAIL: forward that flit, increment npkt, update last-winner pointer to sel, go to IDLE next cycle.
REQ-018 SHALL: BUSY with a non-TAIL flit -> stay BUSY; no flow control; one flit forwarded per cycle.
REQ-019 SHALL: ignore all req changes while in GRANT or BUSY, including new requests from other ports.
REQ-020 SHALL: on a simultaneous TAIL and new req, start arbitration only in the following IDLE cycle; inter-packet gap is therefore >= 1 cycle (TAIL at t, IDLE at t+1, GRANT at t+2).
REQ-021 SHALL: latency from req sampled in IDLE at cycle t to ack at t+1.
REQ-022 SHALL: packets are >= 2 flits (HEAD ... TAIL); a TAIL flow in the GRANT cycle is not examined.
REQ-023 SHALL: pkto=0 whenever we=0.
REQ-024 SHALL: a requester that just finished may win again only if no other port requests in that IDLE cycle.

Reset
REQ-025 SHALL: on rst: state=IDLE, ack=0, sel=0, we=0, busy=0, pkto=0, npkt=0, last-winner pointer=3 so that port 0 has top priority.
REQ-026 SHALL: rst mid-packet abandons the packet immediately; npkt is not incremented, and the next grant starts clean.

Verification
REQ-027 SHALL: after rst, req=4'b0001, pkt0 = HEAD,BODY,TAIL -> ack=4'b0001 one cycle later; we=1 for 3 cycles; pkto = HEAD,BODY,TAIL; npkt=1; busy falls after TAIL.
REQ-028 SHALL: after rst, req=4'b1111 held constant, 2-flit packets -> grant order 0,1,2,3,0; each ack a single-cycle pulse.
REQ-029 SHALL: port 2 in BUSY; port 1 raises req mid-packet -> no ack until port 2's TAIL is forwarded; ack=4'b0010 exactly 2 cycles after the TAIL cycle.
REQ-030 SHALL: rst asserted during BUSY on the 3rd flit -> next cycle we=0, busy=0, ack=0, npkt unchanged at 0, pointer=3.
REQ-031 SHALL: npkt preloaded near saturation by running 65537 packets (or forced) -> npkt stays 16'hFFFF.
REQ-032 SHALL: req=4'b0101 with last winner=0 -> winner=2; then with req=4'b0101 again -> winner=0.

Source files
------------

// File: rtl/outarb.sv
// outarb: round-robin output-port arbiter; grants one input port and forwards its
// packet flit by flit until the TAIL flit, counting completed packets.
`ifndef PORT
`define PORT 3
`endif
`ifndef PKTW
`define PKTW 15
`endif
`ifndef FLOWBH
`define FLOWBH 15
`endif
`ifndef FLOWBL
`define FLOWBL 14
`endif
`ifndef TAIL
`define TAIL 2'b10
`endif

module outarb #(
    parameter logic [15:0] NPKT_INIT = 16'h0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [`PORT:0]   req,
    input  logic [`PKTW:0]   pkt0,
    input  logic [`PKTW:0]   pkt1,
    input  logic [`PKTW:0]   pkt2,
    input  logic [`PKTW:0]   pkt3,
    output logic [3:0]       ack,
    output logic [1:0]       sel,
    output logic [`PKTW:0]   pkto,
    output logic             we,
    output logic             busy,
    output logic [15:0]      npkt
);
    typedef enum logic [1:0] {IDLE, GRANT, BUSY} state_t;
    state_t         state, state_d;
    logic [1:0]     sel_d, last, last_d, win, idx;
    logic [15:0]    npkt_d;
    logic [`PKTW:0] cur;
    logic           tail;

    assign cur  = sel == 2'd0 ? pkt0 : sel == 2'd1 ? pkt1 : sel == 2'd2 ? pkt2 : pkt3;
    assign tail = cur[`FLOWBH:`FLOWBL] == `TAIL;

    // Scan from farthest to nearest so the port right after the last winner wins;
    // the last winner itself (offset 4) is considered least.
    always_comb begin
        win = last;
        idx = '0;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx]) win = idx;
        end
    end

    always_comb begin
        state_d = state;
        sel_d   = sel;
        last_d  = last;
        npkt_d  = npkt;
        ack     = '0;
        we      = 1'b0;
        busy    = 1'b0;
        pkto    = '0;
        case (state)
            IDLE: if (|req) begin
                sel_d   = win;
                state_d = GRANT;
            end
            GRANT: begin
                ack     = 4'b0001 << sel;
                we      = 1'b1;
                busy    = 1'b1;
                pkto    = cur;
                state_d = BUSY;
            end
            BUSY: begin
                we   = 1'b1;
                busy = 1'b1;
                pkto = cur;
                if (tail) begin
                    npkt_d  = &npkt ? npkt : npkt + 16'd1;
                    last_d  = sel;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sel   <= '0;
            last  <= 2'd3;
            npkt  <= NPKT_INIT;
        end else begin
            state <= state_d;
            sel   <= sel_d;
            last  <= last_d;
            npkt  <= npkt_d;
        end
    end
endmodule

// File: tb/tb_outarb.sv
// tb_outarb: scoreboard bench for outarb; input FIFOs feed the DUT, a monitor
// checks every forwarded flit against hand-ordered expected flits.
`ifndef PORT
`define PORT 3
`endif
`ifndef PKTW
`define PKTW 15
`endif
`ifndef FLOWBH
`define FLOWBH 15
`endif
`ifndef FLOWBL
`define FLOWBL 14
`endif
`ifndef TAIL
`define TAIL 2'b10
`endif

module tb_outarb;
    localparam logic [1:0] HEAD = 2'b01, BODY = 2'b00, TAILF = 2'b10;

    typedef struct packed {
        logic [3:0]     ack;
        logic [1:0]     sel;
        logic [`PKTW:0] pkto;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [`PORT:0] req = '0;
    logic [`PKTW:0] hd [4];
    logic [3:0] ack, ack2;
    logic [1:0] sel, sel2;
    logic [`PKTW:0] pkto, pkto2;
    logic we, we2, busy, busy2;
    logic [15:0] npkt, npkt2;

    exp_t sb[$];
    logic [`PKTW:0] fifo [4][$];
    logic pop_v = 1'b0;
    logic [1:0] pop_p = '0;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    outarb dut (
        .clk(clk), .rst(rst), .req(req),
        .pkt0(hd[0]), .pkt1(hd[1]), .pkt2(hd[2]), .pkt3(hd[3]),
        .ack(ack), .sel(sel), .pkto(pkto), .we(we), .busy(busy), .npkt(npkt)
    );

    // Second instance starts near saturation so the counter ceiling is reachable quickly.
    outarb #(.NPKT_INIT(16'hFFFD)) dut_sat (
        .clk(clk), .rst(rst), .req(req),
        .pkt0(hd[0]), .pkt1(hd[1]), .pkt2(hd[2]), .pkt3(hd[3]),
        .ack(ack2), .sel(sel2), .pkto(pkto2), .we(we2), .busy(busy2), .npkt(npkt2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic upd();
        for (int i = 0; i < 4; i++) hd[i] = fifo[i].size() > 0 ? fifo[i][0] : '0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Queue a packet on port p and its expected output flits on the scoreboard.
    task automatic load(input int p, input int nbody, input int base);
        logic [`PKTW:0] f;
        exp_t e;
        for (int i = 0; i < nbody + 2; i++) begin
            f = {i == 0 ? HEAD : i == nbody + 1 ? TAILF : BODY, 14'(base + i)};
            fifo[p].push_back(f);
            e.ack  = i == 0 ? 4'(1 << p) : 4'b0;
            e.sel  = 2'(p);
            e.pkto = f;
            sb.push_back(e);
        end
        upd();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin
            tick(1);
            n++;
        end
        chk("drain_timeout", 32'(n >= 200), 32'd0);
        tick(1);
    endtask

    task automatic do_rst();
        rst = 1'b1;
        req = '0;
        tick(2);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        pop_v = 1'b0;
        if (!rst) begin
            if (we) begin
                if (sb.size() == 0) begin
                    chk("unexpected_flit", 32'(pkto), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("flit_ack", 32'(ack), 32'(e.ack));
                    chk("flit_sel", 32'(sel), 32'(e.sel));
                    chk("flit_pkto", 32'(pkto), 32'(e.pkto));
                    chk("flit_busy", 32'(busy), 32'd1);
                end
                pop_v = 1'b1;
                pop_p = sel;
            end else begin
                chk("idle_pkto", 32'(pkto), 32'd0);
                chk("idle_ack", 32'(ack), 32'd0);
            end
        end
    end

    // Input FIFOs pop the flit forwarded in the previous cycle, just after the edge.
    always begin
        @(posedge clk);
        #1;
        if (pop_v && fifo[pop_p].size() > 0) void'(fifo[pop_p].pop_front());
        upd();
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        upd();
        tick(2);
        rst = 1'b0;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pkto", 32'(pkto), 32'd0);
        chk("rst_npkt", 32'(npkt), 32'd0);

        // Single 3-flit packet from port 0
        load(0, 1, 16'h100);
        req = 4'b0001;
        chk("t1_ack_idle", 32'(ack), 32'd0);
        tick(1);
        chk("t1_ack", 32'(ack), 32'b0001);
        chk("t1_we", 32'(we), 32'd1);
        req = '0;
        tick(2);
        chk("t1_busy_tail", 32'(busy), 32'd1);
        tick(1);
        chk("t1_busy_end", 32'(busy), 32'd0);
        chk("t1_we_end", 32'(we), 32'd0);
        chk("t1_npkt", 32'(npkt), 32'd1);
        chk("t1_npkt_sat", 32'(npkt2), 32'hFFFE);
        drain();

        // All ports requesting: rotation 0,1,2,3,0
        do_rst();
        load(0, 0, 16'h200);
        load(1, 0, 16'h210);
        load(2, 0, 16'h220);
        load(3, 0, 16'h230);
        load(0, 0, 16'h240);
        req = 4'b1111;
        tick(14);
        req = '0;
        drain();
        chk("t2_npkt", 32'(npkt), 32'd5);

        // Last winner 0, req 0101 -> 2 then 0
        do_rst();
        load(0, 0, 16'h300);
        load(2, 0, 16'h310);
        load(0, 0, 16'h320);
        req = 4'b0001;
        tick(1);
        req = 4'b0101;
        tick(7);
        req = '0;
        drain();

        // New request during busy packet waits; grant two cycles after TAIL
        do_rst();
        load(2, 2, 16'h400);
        load(1, 0, 16'h410);
        req = 4'b0100;
        tick(1);
        chk("t4_ack2", 32'(ack), 32'b0100);
        req = '0;
        tick(1);
        req = 4'b0010;
        chk("t4_ack_b1", 32'(ack), 32'd0);
        tick(1);
        chk("t4_ack_b2", 32'(ack), 32'd0);
        tick(1);
        chk("t4_ack_tail", 32'(ack), 32'd0);
        chk("t4_we_tail", 32'(we), 32'd1);
        tick(1);
        chk("t4_ack_gap", 32'(ack), 32'd0);
        chk("t4_we_gap", 32'(we), 32'd0);
        tick(1);
        chk("t4_ack1", 32'(ack), 32'b0010);
        req = '0;
        drain();

        // Reset on third flit abandons the packet
        do_rst();
        load(0, 3, 16'h500);
        req = 4'b0001;
        tick(1);
        req = '0;
        tick(2);
        rst = 1'b1;
        repeat (3) void'(sb.pop_back());
        tick(1);
        rst = 1'b0;
        chk("t5_we", 32'(we), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_ack", 32'(ack), 32'd0);
        chk("t5_npkt", 32'(npkt), 32'd0);
        fifo[0].delete();
        upd();
        load(0, 0, 16'h520);
        load(1, 0, 16'h530);
        req = 4'b0011;
        tick(1);
        chk("t5_ptr_ack", 32'(ack), 32'b0001);
        tick(3);
        req = '0;
        drain();
        chk("t5_npkt2", 32'(npkt), 32'd2);
        chk("t5_sat", 32'(npkt2), 32'hFFFF);

        // One more packet: saturated counter must hold
        load(3, 1, 16'h600);
        req = 4'b1000;
        tick(1);
        req = '0;
        drain();
        chk("t6_npkt", 32'(npkt), 32'd3);
        chk("t6_sat", 32'(npkt2), 32'hFFFF);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
